// File: rtl/if_fetch.sv
// Instruction-fetch stage: sequential word fetch over a req/gnt bus, returned words queued with their PCs.
// Optional macro IF_PREFETCH_EN: 2-entry buffer and 2 outstanding requests (otherwise 1 and 1).
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

`ifdef IF_PREFETCH_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif
  localparam logic [2:0] CAP_N    = 3'(CAP);
  localparam logic       LAST_IDX = 1'(CAP - 1);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, resp_pc;
  logic [1:0]  outstanding, outstanding_nxt;
  logic [1:0]  occ, occ_nxt;
  logic        head, tail;
  logic [31:0] buf_pc   [2];
  logic [31:0] buf_inst [2];

  logic        issue, resp, pop;
  logic [2:0]  inflight;
  logic [2:0]  hard_used_nxt;
  logic        exhausted_nxt;

  function automatic logic ptr_inc(input logic p);
    return (p == LAST_IDX) ? 1'b0 : ~p;
  endfunction

  assign inst_valid_o = (occ != 2'd0);
  assign pop          = inst_valid_o && !stall_i;
  assign inflight     = {1'b0, outstanding} + {1'b0, occ} - {2'b00, pop};
  assign ibus_req_o   = (state == S_FETCH) && (inflight < CAP_N);
  assign issue        = ibus_req_o && ibus_gnt_i;
  assign resp         = ibus_rvalid_i && (outstanding != 2'd0);
  assign ibus_addr_o  = fetch_pc;
  assign pc_o         = inst_valid_o ? buf_pc[head] : resp_pc;
  assign inst_o       = inst_valid_o ? buf_inst[head] : 32'h0;

  always_comb begin
    outstanding_nxt = outstanding;
    unique case ({issue, resp})
      2'b10:   outstanding_nxt = outstanding + 2'd1;
      2'b01:   outstanding_nxt = outstanding - 2'd1;
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_comb begin
    occ_nxt = occ;
    unique case ({resp, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  // Wait only when no credit would exist even if the head were popped next cycle,
  // so S_WAIT never suppresses a request that S_FETCH would have made.
  assign hard_used_nxt = {1'b0, outstanding_nxt} + {1'b0, occ_nxt}
                       - {2'b00, (occ_nxt != 2'd0)};
  assign exhausted_nxt = (hard_used_nxt >= CAP_N);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: if (exhausted_nxt) state_nxt = S_WAIT;
      S_WAIT:  if (!exhausted_nxt) state_nxt = S_FETCH;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= 2'd0;
      occ         <= 2'd0;
      head        <= 1'b0;
      tail        <= 1'b0;
    end else begin
      state       <= state_nxt;
      outstanding <= outstanding_nxt;
      occ         <= occ_nxt;
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (resp) begin
        resp_pc <= resp_pc + 32'd4;
        tail    <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
    end
  end

  // Buffer payload carries no reset; occ qualifies every read.
  always_ff @(posedge clk) begin
    if (resp) begin
      buf_pc[tail]   <= resp_pc;
      buf_inst[tail] <= ibus_rdata_i;
    end
  end

endmodule
